// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and sizing helper for the reset sequencer
package reset_seq_pkg;
  typedef enum logic [1:0] {SYNC, HOLD, RELEASE, DONE} state_t;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/reset_sync.sv
// reset_sync: async-assert, sync-deassert flop chain for the board reset
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic rst_sync
);
  logic [STAGES-1:0] chain;
  always_ff @(posedge clk or posedge reset)
    if (reset) chain <= '1;
    else chain <= {chain[STAGES-2:0], 1'b0};
  assign rst_sync = chain[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staggered synchronous release of block resets with software re-reset
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_RST        = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sw_rst_req_i,
  output logic               sw_rst_ack_o,
  output logic [NUM_RST-1:0] rst_o,
  output logic               rst_done_o
);
  localparam int CW = $clog2(max2(HOLD_CYCLES, STAGGER_CYCLES) + 1);
  localparam int IW = $clog2(NUM_RST + 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          rst_sync;
  reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .rst_sync (rst_sync)
  );
  // every output is a flop so block resets never glitch
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= SYNC;
      cnt          <= '0;
      idx          <= '0;
      rst_o        <= '1;
      rst_done_o   <= 1'b0;
      sw_rst_ack_o <= 1'b0;
    end else begin
      sw_rst_ack_o <= 1'b0;
      case (state)
        SYNC: if (!rst_sync) begin
          state <= HOLD;
          cnt   <= '0;
        end
        HOLD: if (cnt == CW'(HOLD_CYCLES - 1)) begin
          state    <= RELEASE;
          rst_o[0] <= 1'b0;
          idx      <= IW'(1);
          cnt      <= '0;
        end else cnt <= cnt + 1'b1;
        RELEASE: if (idx == IW'(NUM_RST)) begin
          state      <= DONE;
          rst_done_o <= 1'b1;
        end else if (cnt == CW'(STAGGER_CYCLES - 1)) begin
          rst_o <= rst_o & ~(NUM_RST'(1) << idx);
          idx   <= idx + 1'b1;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        DONE: if (sw_rst_req_i) begin
          state        <= HOLD;
          cnt          <= '0;
          rst_o        <= '1;
          rst_done_o   <= 1'b0;
          sw_rst_ack_o <= 1'b1;
        end
        default: state <= SYNC;
      endcase
    end
endmodule
